agu_stream: RTL and testbench

- Parametrised successor to the NWC/NTT address generation unit.
- Produces the radix-2^RADIX_K butterfly address sequence for every stage of an N = 2^LOGN transform, in forward or inverse stage order.
- Adds a valid/ready output handshake with full backpressure, a start/busy/done control FSM and per-address stage/group tags.
- Sits between the NTT controller and the memory-bank mapper.

---
 rtl/agu_stream.sv | 173 +++++++++++++++++
 tb/tb_agu_stream.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/agu_stream.sv
// agu_stream: radix-2^RADIX_K NTT/NWC butterfly address generator with a
// valid/ready output register, start/busy/done control and per-address stage tags.
module agu_stream #(
  parameter  int LOGN    = 10,
  parameter  int RADIX_K = 2,
  localparam int STAGES  = LOGN / RADIX_K,
  localparam int STG_W   = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inverse,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [LOGN-1:0]  addr,
  output logic [STG_W-1:0] stage,
  output logic             group_last,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | loading one tuple per free slot of the output register
  // DRAIN | final tuple loaded, waiting for its handshake

  if (LOGN % RADIX_K != 0) begin : g_cfg_err
    $error("agu_stream: LOGN must be a multiple of RADIX_K");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam int              SH_W      = $clog2(LOGN + 1) + 1;
  localparam logic [LOGN-1:0] ONES      = '1;
  localparam logic [LOGN-1:0] M_TOP     = ONES >> (LOGN - RADIX_K);
  localparam logic [LOGN-1:0] L_LAST    = LOGN'(STAGES - 1);
  localparam logic [SH_W-1:0] BASE_LAST = SH_W'(LOGN - RADIX_K);
  localparam logic [SH_W-1:0] K_STEP    = SH_W'(RADIX_K);
  localparam logic [SH_W-1:0] LOGN_SH   = SH_W'(LOGN);

  state_t           state_q, state_d;
  logic             inv_q, inv_d;
  logic [LOGN-1:0]  l_q, l_d, j_q, j_d, i_q, i_d, m_q, m_d;
  logic [SH_W-1:0]  base_q, base_d;
  logic             valid_q, valid_d, glast_q, glast_d, done_q, done_d;
  logic [LOGN-1:0]  addr_q, addr_d;
  logic [STG_W-1:0] stage_q, stage_d;

  logic [SH_W-1:0]  sh_i;
  logic [LOGN-1:0]  i_top, j_top, j_rev, cur_addr;
  logic             last_stage;

  // base_q tracks RADIX_K*l incrementally so no multiplier is needed
  assign sh_i       = base_q + K_STEP;
  assign i_top      = ONES >> sh_i;
  assign j_top      = ~(ONES << base_q);
  assign last_stage = inv_q ? (l_q == '0) : (l_q == L_LAST);

  // Full-width reversal of j already lands rev(j, RADIX_K*l) in the top bits,
  // because j never exceeds j_top.
  always_comb begin
    j_rev = '0;
    for (int b = 0; b < LOGN; b++) j_rev[b] = j_q[LOGN-1-b];
  end

  assign cur_addr = j_rev + (m_q << (LOGN_SH - sh_i)) + i_q;

  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    l_d     = l_q;
    base_d  = base_q;
    j_d     = j_q;
    i_d     = i_q;
    m_d     = m_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    stage_d = stage_q;
    glast_d = glast_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          inv_d   = inverse;
          l_d     = inverse ? L_LAST : '0;
          base_d  = inverse ? BASE_LAST : '0;
          j_d     = '0;
          i_d     = '0;
          m_d     = '0;
        end
      end
      S_RUN: begin
        if (!valid_q || out_ready) begin
          valid_d = 1'b1;
          addr_d  = cur_addr;
          stage_d = l_q[STG_W-1:0];
          glast_d = (m_q == M_TOP);
          if (m_q != M_TOP) begin
            m_d = m_q + 1'b1;
          end else begin
            m_d = '0;
            if (i_q != i_top) begin
              i_d = i_q + 1'b1;
            end else begin
              i_d = '0;
              if (j_q != j_top) begin
                j_d = j_q + 1'b1;
              end else begin
                j_d = '0;
                if (last_stage) begin
                  state_d = S_DRAIN;
                end else if (inv_q) begin
                  l_d    = l_q - 1'b1;
                  base_d = base_q - K_STEP;
                end else begin
                  l_d    = l_q + 1'b1;
                  base_d = base_q + K_STEP;
                end
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      inv_q   <= 1'b0;
      l_q     <= '0;
      base_q  <= '0;
      j_q     <= '0;
      i_q     <= '0;
      m_q     <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      stage_q <= '0;
      glast_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      l_q     <= l_d;
      base_q  <= base_d;
      j_q     <= j_d;
      i_q     <= i_d;
      m_q     <= m_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      stage_q <= stage_d;
      glast_q <= glast_d;
      done_q  <= done_d;
    end
  end

  assign out_valid  = valid_q;
  assign addr       = addr_q;
  assign stage      = stage_q;
  assign group_last = glast_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_agu_stream.sv
// Directed bench for agu_stream: LOGN=4/RADIX_K=2 passes (fwd, inv, stall,
// ignored restart, mid-pass reset) and a LOGN=3/RADIX_K=1 pass.
module tb_agu_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, inverse_a, ready_a;
  logic       valid_a, glast_a, busy_a, done_a;
  logic [3:0] addr_a;
  logic [0:0] stage_a;
  logic       start_b, inverse_b, ready_b;
  logic       valid_b, glast_b, busy_b, done_b;
  logic [2:0] addr_b;
  logic [1:0] stage_b;

  agu_stream #(.LOGN(4), .RADIX_K(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .inverse(inverse_a), .out_ready(ready_a),
    .out_valid(valid_a), .addr(addr_a), .stage(stage_a), .group_last(glast_a),
    .busy(busy_a), .done(done_a)
  );

  agu_stream #(.LOGN(3), .RADIX_K(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .inverse(inverse_b), .out_ready(ready_b),
    .out_valid(valid_b), .addr(addr_b), .stage(stage_b), .group_last(glast_b),
    .busy(busy_b), .done(done_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int a_s0[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  int a_s1[16] = '{0, 1, 2, 3, 8, 9, 10, 11, 4, 5, 6, 7, 12, 13, 14, 15};
  // hand-derived from the address formula with m innermost, then i, then j
  int b_seq[24] = '{0, 4, 1, 5, 2, 6, 3, 7,
                    0, 2, 1, 3, 4, 6, 5, 7,
                    0, 1, 4, 5, 2, 3, 6, 7};

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  function automatic bit a_first_is_s0(input bit inv, input int k);
    return (k < 16) ^ inv;
  endfunction

  function automatic int exp_a_addr(input bit inv, input int k);
    return a_first_is_s0(inv, k) ? a_s0[k % 16] : a_s1[k % 16];
  endfunction

  function automatic int exp_a_stage(input bit inv, input int k);
    return a_first_is_s0(inv, k) ? 0 : 1;
  endfunction

  task automatic pass_a(input bit inv, input int stall_idx, input int stall_len,
                        input int dup_idx, input int rst_idx);
    int cnt, cyc, stall_left;
    bit stalled;
    cnt = 0; cyc = 0; stall_left = 0; stalled = 0;
    @(negedge clk);
    start_a = 1'b1; inverse_a = inv; ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; inverse_a = !inv;
    check("a_lat_valid0", int'(valid_a), 0);
    check("a_busy_run", int'(busy_a), 1);
    @(negedge clk);
    while (cnt < 32 && cyc < 200) begin
      check("a_valid", int'(valid_a), 1);
      check("a_addr", int'(addr_a), exp_a_addr(inv, cnt));
      check("a_stage", int'(stage_a), exp_a_stage(inv, cnt));
      check("a_glast", int'(glast_a), int'(cnt % 4 == 3));
      check("a_no_done", int'(done_a), 0);
      if (cnt == rst_idx) begin
        rst = 1'b1;
        #1;
        check("a_rst_valid", int'(valid_a), 0);
        check("a_rst_addr", int'(addr_a), 0);
        check("a_rst_stage", int'(stage_a), 0);
        check("a_rst_glast", int'(glast_a), 0);
        check("a_rst_busy", int'(busy_a), 0);
        check("a_rst_done", int'(done_a), 0);
        rst = 1'b0;
        start_a = 1'b0;
        ready_a = 1'b1;
        return;
      end
      if (cnt == stall_idx && !stalled) begin
        stalled = 1'b1;
        stall_left = stall_len;
      end
      if (stall_left > 0) begin
        ready_a = 1'b0;
        stall_left--;
      end else begin
        ready_a = 1'b1;
      end
      start_a = (cnt == dup_idx);
      if (ready_a) cnt++;
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    check("a_pass_len", cnt, 32);
    check("a_done_pulse", int'(done_a), 1);
    check("a_busy_done", int'(busy_a), 0);
    check("a_valid_done", int'(valid_a), 0);
    @(negedge clk);
    check("a_done_low", int'(done_a), 0);
    check("a_busy_idle", int'(busy_a), 0);
  endtask

  task automatic pass_b();
    int cnt, cyc;
    cnt = 0; cyc = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_lat_valid0", int'(valid_b), 0);
    @(negedge clk);
    while (cnt < 24 && cyc < 100) begin
      check("b_valid", int'(valid_b), 1);
      check("b_addr", int'(addr_b), b_seq[cnt]);
      check("b_stage", int'(stage_b), cnt / 8);
      check("b_glast", int'(glast_b), int'(cnt % 2 == 1));
      check("b_no_done", int'(done_b), 0);
      cnt++;
      @(negedge clk);
      cyc++;
    end
    check("b_pass_len", cnt, 24);
    check("b_done_pulse", int'(done_b), 1);
    check("b_busy_done", int'(busy_b), 0);
    @(negedge clk);
    check("b_done_low", int'(done_b), 0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; inverse_a = 1'b0; ready_a = 1'b1;
    start_b = 1'b0; inverse_b = 1'b0; ready_b = 1'b1;
    @(negedge clk);
    check("rst_valid", int'(valid_a), 0);
    check("rst_addr", int'(addr_a), 0);
    check("rst_stage", int'(stage_a), 0);
    check("rst_glast", int'(glast_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_b_valid", int'(valid_b), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy_a), 0);

    pass_a(1'b0, -1, 0, -1, -1);
    pass_a(1'b1, -1, 0, -1, -1);
    pass_a(1'b0, 2, 5, -1, -1);
    pass_a(1'b0, -1, 0, 9, -1);
    pass_a(1'b0, -1, 0, -1, 19);
    pass_a(1'b0, -1, 0, -1, -1);
    pass_b();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
